// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings and state type for the memory-stage access path.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dmem_state_t;

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// Combinational byte-lane placement for stores and extraction/extension for loads.
module lsu_lane_format
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted_s;

  assign shifted_s = rdata >> {offset, 3'b000};

  // Store lane enables and replicated write data
  always_comb begin
    byte_en = 4'b0000;
    wdata   = 32'h0000_0000;
    case (func3)
      F3_B, F3_BU: begin
        byte_en = 4'b0001 << offset;
        wdata   = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        byte_en = offset[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{store_data[15:0]}};
      end
      F3_W: begin
        byte_en = 4'b1111;
        wdata   = store_data;
      end
      default: begin
        byte_en = 4'b0000;
        wdata   = 32'h0000_0000;
      end
    endcase
  end

  // Load extraction with sign or zero extension
  always_comb begin
    load_data = 32'h0000_0000;
    case (func3)
      F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   load_data = {24'h00_0000, shifted_s[7:0]};
      F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   load_data = {16'h0000, shifted_s[15:0]};
      F3_W:    load_data = shifted_s;
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage controller: sequences one load/store onto the data bus, stalls the
// pipeline while it is outstanding, and formats store lanes and load results.
module dmem_access_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
)
(
  input  logic        clk,
  input  logic        rstN,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memByteEn,
  input  logic [31:0] memRdata,
  input  logic        memReady,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        accessFault,
  output logic        busTimeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_t      state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       func3_r;
  logic [1:0]       offset_r;
  logic             mem_we_r;
  logic [31:0]      mem_addr_r, mem_wdata_r, load_data_r;
  logic [3:0]       mem_be_r;
  logic             load_valid_r, bus_timeout_r;

  logic access_s, misalign_s, fault_s;
  logic accept_s, stall_s, fault_out_s, done_ok_s, timeout_s;
  logic [2:0]  fmt_func3_s;
  logic [1:0]  fmt_offset_s;
  logic [3:0]  fmt_be_s;
  logic [31:0] fmt_wdata_s, fmt_load_s;

  assign access_s = memRead ^ memWrite;

  // Natural-alignment check by access size
  always_comb begin
    misalign_s = 1'b0;
    case (func3[1:0])
      2'b01:   misalign_s = addr[0];
      2'b10:   misalign_s = |addr[1:0];
      default: misalign_s = 1'b0;
    endcase
  end

  assign fault_s = (memRead & memWrite) |
                   (access_s & (~f3_legal(func3, memWrite) | misalign_s));

  // In IDLE the formatter sees the incoming op; afterwards it sees the latched one.
  assign fmt_func3_s  = (state_r == IDLE) ? func3     : func3_r;
  assign fmt_offset_s = (state_r == IDLE) ? addr[1:0] : offset_r;

  lsu_lane_format u_fmt (
    .func3      (fmt_func3_s),
    .offset     (fmt_offset_s),
    .store_data (storeData),
    .rdata      (memRdata),
    .byte_en    (fmt_be_s),
    .wdata      (fmt_wdata_s),
    .load_data  (fmt_load_s)
  );

  // Next-state and combinational handshake decode
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    stall_s     = 1'b0;
    fault_out_s = 1'b0;
    done_ok_s   = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (fault_s) begin
          fault_out_s = 1'b1;
        end else if (access_s) begin
          accept_s    = 1'b1;
          stall_s     = 1'b1;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (memReady) begin
          done_ok_s   = 1'b1;
          state_nxt_s = DONE;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and BUSY wait counter
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == BUSY && !done_ok_s && !timeout_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  // Bus-side latches and load result registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem_addr_r    <= 32'h0000_0000;
      mem_we_r      <= 1'b0;
      mem_be_r      <= 4'b0000;
      mem_wdata_r   <= 32'h0000_0000;
      func3_r       <= 3'b000;
      offset_r      <= 2'b00;
      load_data_r   <= 32'h0000_0000;
      load_valid_r  <= 1'b0;
      bus_timeout_r <= 1'b0;
    end else begin
      if (accept_s) begin
        mem_addr_r  <= {addr[31:2], 2'b00};
        mem_we_r    <= memWrite;
        mem_be_r    <= fmt_be_s;
        mem_wdata_r <= fmt_wdata_s;
        func3_r     <= func3;
        offset_r    <= addr[1:0];
      end
      if (done_ok_s) begin
        load_data_r <= fmt_load_s;
      end else if (timeout_s) begin
        load_data_r <= 32'h0000_0000;
      end
      load_valid_r  <= done_ok_s & ~mem_we_r;
      bus_timeout_r <= timeout_s;
    end
  end

  // Combinational outputs are gated by reset so an abandoned access drops at once.
  assign stall       = rstN & stall_s;
  assign accessFault = rstN & fault_out_s;
  assign memReq      = (state_r == BUSY);
  assign memWe       = mem_we_r;
  assign memAddr     = mem_addr_r;
  assign memByteEn   = mem_be_r;
  assign memWdata    = mem_wdata_r;
  assign loadData    = load_data_r;
  assign loadValid   = load_valid_r;
  assign busTimeout  = bus_timeout_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a transaction-level expectation model.
module tb_dmem_access_ctrl;
  import riscv_mem_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        memRead, memWrite, memReady;
  logic [2:0]  func3;
  logic [31:0] addr, storeData, memRdata;
  logic        memReq, memWe, stall, loadValid, accessFault, busTimeout;
  logic [31:0] memAddr, memWdata, loadData;
  logic [3:0]  memByteEn;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstN(rstN), .memRead(memRead), .memWrite(memWrite),
    .func3(func3), .addr(addr), .storeData(storeData), .memReq(memReq),
    .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memByteEn(memByteEn),
    .memRdata(memRdata), .memReady(memReady), .stall(stall), .loadData(loadData),
    .loadValid(loadValid), .accessFault(accessFault), .busTimeout(busTimeout)
  );

  typedef struct {
    bit rd; bit wr; logic [2:0] f3; logic [31:0] addr; logic [31:0] sdata;
    logic [31:0] rdata; int waits; bit lit; logic [3:0] lbe; logic [31:0] lwd; logic [31:0] lld;
  } txn_t;

  typedef struct {
    bit stall; bit req; bit fault; bit lv; bit tmo; bit we;
    bit chk_bus; bit chk_wd; bit chk_ld;
    logic [31:0] addr; logic [31:0] wd; logic [31:0] ld; logic [3:0] be;
  } exp_t;

  exp_t        ex;
  bit          ex_on = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_ld;
  bit          ld_known;
  txn_t        tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] sd,
                              logic [31:0] rdat, int waits, bit lit, logic [3:0] lbe,
                              logic [31:0] lwd, logic [31:0] lld);
    txn_t t;
    t.rd = rd; t.wr = wr; t.f3 = f3; t.addr = a; t.sdata = sd; t.rdata = rdat;
    t.waits = waits; t.lit = lit; t.lbe = lbe; t.lwd = lwd; t.lld = lld;
    return t;
  endfunction

  function automatic int size_of(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(txn_t t);
    if (!(t.rd ^ t.wr)) return 1'b0;
    if (!(t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (t.wr && t.f3[2]) return 1'b0;
    return (t.addr % size_of(t.f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(txn_t t);
    int sz = size_of(t.f3);
    return 4'(((1 << sz) - 1) << t.addr[1:0]);
  endfunction

  function automatic logic [31:0] m_wd(txn_t t);
    int sz = size_of(t.f3);
    if (sz == 1) return {24'h0, t.sdata[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'h0, t.sdata[15:0]} * 32'h0001_0001;
    return t.sdata;
  endfunction

  function automatic logic [31:0] m_ld(txn_t t);
    int sz = size_of(t.f3);
    logic [31:0] r, mask, v;
    r    = t.rdata >> (8 * int'(t.addr[1:0]));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = r & mask;
    if (!t.f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.stall = 1'b0; e.req = 1'b0; e.fault = 1'b0; e.lv = 1'b0; e.tmo = 1'b0; e.we = 1'b0;
    e.chk_bus = 1'b0; e.chk_wd = 1'b0; e.chk_ld = ld_known;
    e.addr = 32'h0; e.wd = 32'h0; e.ld = last_ld; e.be = 4'h0;
    return e;
  endfunction

  function automatic exp_t busy_exp(txn_t t);
    exp_t e = idle_exp();
    e.stall = 1'b1; e.req = 1'b1; e.chk_bus = 1'b1; e.we = t.wr;
    e.addr = {t.addr[31:2], 2'b00}; e.be = m_be(t); e.chk_wd = t.wr; e.wd = m_wd(t);
    return e;
  endfunction

  task automatic run_txn(input txn_t t);
    bit ok, bad, tmo;
    int nb;
    logic [31:0] ld;
    ok  = legal(t);
    bad = (t.rd | t.wr) && !ok;
    tmo = (t.waits >= T);
    nb  = tmo ? T : t.waits + 1;
    @(posedge clk); #1;
    memRead = t.rd; memWrite = t.wr; func3 = t.f3; addr = t.addr; storeData = t.sdata;
    memReady = 1'b1; memRdata = 32'h1111_2222;
    ex = idle_exp(); ex.stall = ok; ex.fault = bad; ex_on = 1'b1;
    if (!ok) return;
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      memReady = (i == t.waits);
      memRdata = (i == t.waits) ? t.rdata : 32'h5A5A_5A5A;
      ex = busy_exp(t);
      if (t.lit && i == 0) begin
        @(negedge clk); #1;
        check("lit_byte_en", {28'h0, memByteEn}, {28'h0, t.lbe});
        if (t.wr) check("lit_wdata", memWdata, t.lwd);
      end
    end
    ld = tmo ? 32'h0 : m_ld(t);
    if (t.rd || tmo) begin
      last_ld = ld; ld_known = 1'b1;
    end else begin
      ld_known = 1'b0;
    end
    @(posedge clk); #1;
    memReady = 1'b1; memRdata = 32'h0BAD_F00D;
    ex = idle_exp(); ex.lv = t.rd && !tmo; ex.tmo = tmo;
    if (t.lit && t.rd) begin
      @(negedge clk); #1;
      check("lit_load", loadData, t.lld);
    end
  endtask

  // Per-cycle comparison against the model expectation
  always @(negedge clk) begin
    if (ex_on) begin
      check("stall", {31'h0, stall}, {31'h0, ex.stall});
      check("memReq", {31'h0, memReq}, {31'h0, ex.req});
      check("accessFault", {31'h0, accessFault}, {31'h0, ex.fault});
      check("loadValid", {31'h0, loadValid}, {31'h0, ex.lv});
      check("busTimeout", {31'h0, busTimeout}, {31'h0, ex.tmo});
      if (ex.chk_bus) begin
        check("memWe", {31'h0, memWe}, {31'h0, ex.we});
        check("memAddr", memAddr, ex.addr);
        check("memByteEn", {28'h0, memByteEn}, {28'h0, ex.be});
        if (ex.chk_wd) check("memWdata", memWdata, ex.wd);
      end
      if (ex.chk_ld) check("loadData", loadData, ex.ld);
    end
  end

  initial begin
    rstN = 1'b0; memRead = 1'b0; memWrite = 1'b0; func3 = 3'b000; addr = 32'h0;
    storeData = 32'h0; memRdata = 32'h0; memReady = 1'b0;
    last_ld = 32'h0; ld_known = 1'b1;

    tbl.push_back(mk(1, 0, F3_W,  32'h100, 32'h0,        32'hDEAD_BEEF, 0, 1, 4'b1111, 32'h0,        32'hDEAD_BEEF));
    tbl.push_back(mk(1, 0, F3_B,  32'h103, 32'h0,        32'h8012_3456, 3, 1, 4'b1000, 32'h0,        32'hFFFF_FF80));
    tbl.push_back(mk(1, 0, F3_BU, 32'h103, 32'h0,        32'h8012_3456, 3, 1, 4'b1000, 32'h0,        32'h0000_0080));
    tbl.push_back(mk(0, 1, F3_H,  32'h022, 32'h1234_ABCD, 32'h0,        1, 1, 4'b1100, 32'hABCD_ABCD, 32'h0));
    tbl.push_back(mk(0, 1, F3_B,  32'h041, 32'h0000_00A5, 32'h0,        0, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0));
    tbl.push_back(mk(1, 0, F3_H,  32'h042, 32'h0,        32'h9ABC_1234, 0, 1, 4'b1100, 32'h0,        32'hFFFF_9ABC));
    tbl.push_back(mk(1, 0, F3_HU, 32'h040, 32'h0,        32'h9ABC_8765, 2, 1, 4'b0011, 32'h0,        32'h0000_8765));
    tbl.push_back(mk(0, 1, F3_W,  32'h080, 32'hCAFE_F00D, 32'h0,        2, 1, 4'b1111, 32'hCAFE_F00D, 32'h0));
    tbl.push_back(mk(1, 0, F3_W,  32'h101, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(0, 1, F3_H,  32'h021, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 1, F3_W,  32'h100, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(0, 1, F3_BU, 32'h100, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 0, F3_W,  32'h102, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(0, 0, F3_W,  32'h100, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 0, F3_W,  32'h200, 32'h0, 32'h7777_7777, 50, 1, 4'b1111, 32'h0, 32'h0000_0000));
    tbl.push_back(mk(1, 0, F3_W,  32'h204, 32'h0, 32'h0102_0304, 0, 1, 4'b1111, 32'h0, 32'h0102_0304));

    #2;
    check("rst_memReq", {31'h0, memReq}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_loadData", loadData, 32'h0);
    check("rst_loadValid", {31'h0, loadValid}, 32'h0);
    check("rst_memAddr", memAddr, 32'h0);
    check("rst_busTimeout", {31'h0, busTimeout}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rstN = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset asserted in the middle of a BUSY access
    @(posedge clk); #1;
    memRead = 1'b1; memWrite = 1'b0; func3 = F3_W; addr = 32'h300; memReady = 1'b0;
    ex = idle_exp(); ex.stall = 1'b1;
    @(posedge clk); #1;
    ex = busy_exp(mk(1, 0, F3_W, 32'h300, 32'h0, 32'h0, 9, 0, 4'h0, 32'h0, 32'h0));
    @(negedge clk); #1;
    ex_on = 1'b0;
    rstN = 1'b0;
    #1;
    check("mid_rst_memReq", {31'h0, memReq}, 32'h0);
    check("mid_rst_stall", {31'h0, stall}, 32'h0);
    check("mid_rst_memAddr", memAddr, 32'h0);
    check("mid_rst_byteEn", {28'h0, memByteEn}, 32'h0);
    check("mid_rst_loadData", loadData, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1; memRead = 1'b0; last_ld = 32'h0; ld_known = 1'b1;
    run_txn(mk(1, 0, F3_W, 32'h304, 32'h0, 32'h5566_7788, 1, 1, 4'b1111, 32'h0, 32'h5566_7788));

    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0; memReady = 1'b0;
    ex = idle_exp();
    @(posedge clk); #1;
    ex_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage access controller for the 5-stage RISC-V pipeline. Takes the load/store control and operands held in the EX/MEM pipeline register and sequences each access onto a single-ported data-memory bus with a request/ready handshake. Generates the pipeline `stall` that freezes IF through EX/MEM while an access is outstanding. Formats byte/halfword lanes for stores and sign/zero-extends load data for the MEM/WB register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: maximum BUSY cycles without `memReady` before a bus timeout is declared; legal range is 2 and above.
- `CNT_W`, `$clog2(TIMEOUT_CYCLES+1)`: timeout counter width; derived, do not override.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rstN`  in  1  reset, asynchronous, active-low.
- `memRead`  in  1  load in MEM stage, from EX/MEM.
- `memWrite`  in  1  store in MEM stage, from EX/MEM.
- `func3`  in  3  RV32I load/store width code.
- `addr`  in  32  byte address, from ALU output.
- `storeData`  in  32  rs2 value for stores.
- `memReq`  out  1  bus request.
- `memWe`  out  1  bus write enable.
- `memAddr`  out  32  word-aligned address, with `[1:0]` = 0.
- `memWdata`  out  32  lane-replicated store data.
- `memByteEn`  out  4  byte lane enables.
- `memRdata`  in  32  bus read data, valid with `memReady`.
- `memReady`  in  1  bus completion; one sample completes the access.
- `stall`  out  1  freeze IF/ID, ID/EX and EX/MEM registers.
- `loadData`  out  32  extended load result for MEM/WB.
- `loadValid`  out  1  `loadData` valid this cycle.
- `accessFault`  out  1  misaligned, illegal-`func3` or read+write conflict; one-cycle pulse.
- `busTimeout`  out  1  access abandoned; one-cycle pulse.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - Access requested (`memRead ^ memWrite`), `func3` legal and address aligned:
    - assert `stall` combinationally;
    - latch `memAddr`, `memWe`, `memByteEn`, `memWdata`, `func3` and `addr[1:0]`;
    - next state BUSY.
  - Otherwise: no bus activity and `stall` = 0.
- **Fault detection (IDLE only)**
  - `accessFault` = 1, no request, no stall, remain in IDLE, for any of:
    - `memRead & memWrite`;
    - `func3` ∈ {011, 110, 111};
    - a store with `func3[2]` = 1;
    - halfword access with `addr[0]` = 1;
    - word access with `addr[1:0]` ≠ 0.
- **BUSY**
  - `memReq` = 1 and `stall` = 1; bus outputs held stable.
  - `memReady` = 1: capture the formatted read data, next state DONE.
  - Otherwise, if the counter equals `TIMEOUT_CYCLES-1`: set the timeout flag, next state DONE.
  - Otherwise: increment the counter.
- **DONE**
  - `stall` = 0, `memReq` = 0; always returns to IDLE.
  - Completed load: `loadValid` = 1.
  - Timeout: `busTimeout` = 1, `loadValid` = 0, `loadData` = 0.
  - Access inputs in DONE are ignored, because they still describe the retiring instruction.
- **Byte lanes** (`o` = `addr[1:0]`)
  - SB / LB / LBU: `memByteEn` = `1<<o`, `memWdata` = `{4{storeData[7:0]}}`.
  - SH / LH / LHU: `memByteEn` = 0011 if `o[1]` = 0, else 1100; `memWdata` = `{2{storeData[15:0]}}`.
  - SW / LW: `memByteEn` = 1111, `memWdata` = `storeData`.
- **Load extract**
  - `r` = `memRdata >> (8*o)`.
  - LB: sign-extend `r[7:0]`; LBU: zero-extend `r[7:0]`.
  - LH: sign-extend `r[15:0]`; LHU: zero-extend `r[15:0]`.
  - LW: `r` unchanged.
- `memReady` is ignored outside BUSY.

## Timing
- Reset values: state IDLE, counter 0, all outputs 0; `loadData` = 0.
- Asserting `rstN` mid-access drops `memReq` immediately; the abandoned access is never completed.
- Minimum occupancy is 3 cycles:
  - cycle 0: IDLE, access seen, `stall` = 1;
  - cycle 1: BUSY, `memReq` = 1, `memReady` = 1;
  - cycle 2: DONE, `loadValid` = 1.
- Each extra wait cycle in BUSY adds one stall cycle.
- Timeout: DONE is entered after exactly `TIMEOUT_CYCLES` BUSY cycles.
- `loadData` holds its last value outside DONE. Only `loadValid` qualifies it.
- `accessFault` is combinational on the IDLE inputs and lasts one cycle, because the pipeline advances.
- Back-to-back accesses: the next access is accepted in the IDLE cycle following DONE; there is no bubble beyond DONE.

## Structure
- Package `riscv_mem_pkg`:
  - `func3` load/store localparams (`F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101);
  - `dmem_state_t` enum {IDLE, BUSY, DONE}.
- Sub-module `lsu_lane_format`: purely combinational `func3`/offset → `memByteEn`, `memWdata` and load extraction. It is reused by the writeback forwarding path.
- FSM, counter and latches live in `dmem_access_ctrl`.

## Test plan
- **LW, 0 waits:** `addr`=0x100, `memReady` high in first BUSY, `memRdata`=0xDEADBEEF → `memAddr`=0x100, `memByteEn`=1111, two stall cycles, `loadData`=0xDEADBEEF, `loadValid` in cycle 2.
- **LB vs LBU:** `addr`=0x103, `memRdata`=0x80xxxxxx, 3 wait cycles → LB gives 0xFFFFFF80, LBU gives 0x00000080; `stall` high for 5 cycles.
- **SH:** `addr`=0x22, `storeData`=0x1234ABCD → `memWe`=1, `memByteEn`=1100, `memWdata`=0xABCDABCD, `loadValid`=0 in DONE.
- **Faults:** LW at 0x101, SH at 0x21, `func3`=011, `memRead`=`memWrite`=1 → `accessFault` pulse each time, `memReq` never asserted, `stall`=0.
- **Timeout:** `TIMEOUT_CYCLES`=4, `memReady` held 0 → 4 BUSY cycles, then DONE with `busTimeout`=1, `loadData`=0; next access accepted normally.
- **Reset mid-BUSY:** `rstN` low during BUSY → `memReq`, `stall` and all outputs drop to 0 asynchronously; after release, state is IDLE.
